// File: rtl/rr_arbiter_16_pkg.sv
// ============================================================================
// rr_arbiter_16_pkg : shared sizes, FSM encoding and round-robin search
// Rev 1.0
// ============================================================================
`default_nettype none

package rr_arbiter_16_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set request strictly after 'last', wrapping 15->0; 'last' itself is
  // checked last. Returns 'last' when no request is set.
  function automatic logic [IDX_W-1:0] next_rr(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic             found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = last + IDX_W'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_16_grant_decoder.sv
// ============================================================================
// grant_decoder : index + enable to one-hot vector
// Rev 1.0
// ============================================================================
`default_nettype none

module grant_decoder
  import rr_arbiter_16_pkg::*;
(
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_16.sv
// ============================================================================
// rr_arbiter_16 : 16-way round-robin arbiter with completion and hold limit
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  input  logic             DONE,
  output logic [N_REQ-1:0] GNT,
  output logic [IDX_W-1:0] GNT_IDX,
  output logic             GNT_VALID,
  output logic             TIMEOUT
);

  localparam int               CNT_W       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int               HOLD_LAST_I = (MAX_HOLD < 1) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = HOLD_LAST_I[CNT_W-1:0];
  localparam logic             HOLD_EN     = (MAX_HOLD != 0);

  state_e           state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [IDX_W-1:0] last_q,    last_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             timeout_q, timeout_d;

  logic             hold_hit;
  logic             dropped;

  assign hold_hit = HOLD_EN && (cnt_q == HOLD_LAST);
  assign dropped  = !REQ[idx_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          idx_d   = next_rr(REQ, last_q);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (DONE || dropped || hold_hit) begin
          last_d    = idx_q;
          state_d   = IDLE;
          // Timeout is only flagged when the owner neither finished nor left.
          timeout_d = !DONE && !dropped;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign GNT_VALID = (state_q == GRANT);
  assign GNT_IDX   = idx_q;
  assign TIMEOUT   = timeout_q;

  grant_decoder u_grant_decoder (
    .en_i     (GNT_VALID),
    .idx_i    (idx_q),
    .onehot_o (GNT)
  );

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_16.sv
// ============================================================================
// tb_rr_arbiter_16 : directed self-checking bench for rr_arbiter_16
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rr_arbiter_16;

  logic        CLK;
  logic        RST;
  logic [15:0] REQ;
  logic        DONE;
  logic [15:0] GNT;
  logic [3:0]  GNT_IDX;
  logic        GNT_VALID;
  logic        TIMEOUT;

  int n_tests;
  int n_fail;

  rr_arbiter_16 #(.MAX_HOLD(15)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .DONE      (DONE),
    .GNT       (GNT),
    .GNT_IDX   (GNT_IDX),
    .GNT_VALID (GNT_VALID),
    .TIMEOUT   (TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    logic [15:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    check({tag, "_valid"}, 32'(GNT_VALID), 32'd1);
    check({tag, "_idx"},   32'(GNT_IDX),   32'(idx));
    check({tag, "_gnt"},   32'(GNT),       32'(oh));
  endtask

  task automatic expect_idle(input string tag, input logic to_exp);
    check({tag, "_valid"},   32'(GNT_VALID), 32'd0);
    check({tag, "_gnt"},     32'(GNT),       32'd0);
    check({tag, "_timeout"}, 32'(TIMEOUT),   32'(to_exp));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST     = 1'b1;
    REQ     = '0;
    DONE    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_gnt",     32'(GNT),       32'd0);
    check("rst_idx",     32'(GNT_IDX),   32'd0);
    check("rst_valid",   32'(GNT_VALID), 32'd0);
    check("rst_timeout", 32'(TIMEOUT),   32'd0);
    RST = 1'b0;
    tick();

    // Single requester, DONE release
    REQ = 16'h0001;
    tick();
    expect_grant("t1_grant", 0);
    DONE = 1'b1;
    tick();
    expect_idle("t1_rel", 1'b0);
    REQ = '0;
    tick();
    // DONE in IDLE ignored (DONE still high here, REQ zero)
    expect_idle("t1_idle_done", 1'b0);
    DONE = 1'b0;

    // All requesting: LAST=0 so rotation starts at 1
    REQ = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      tick();
      expect_grant("t2_rot", (k + 1) % 16);
      DONE = 1'b1;
      tick();
      check("t2_gap", 32'(GNT), 32'd0);
      DONE = 1'b0;
    end
    REQ = '0;
    tick();

    // Wrap 15 -> 0 -> 15
    REQ = 16'h8000;
    tick();
    expect_grant("t3_g15", 15);
    DONE = 1'b1;
    REQ  = 16'h8001;
    tick();
    expect_idle("t3_rel15", 1'b0);
    DONE = 1'b0;
    tick();
    expect_grant("t3_g0", 0);
    DONE = 1'b1;
    tick();
    expect_idle("t3_rel0", 1'b0);
    DONE = 1'b0;
    tick();
    expect_grant("t3_g15b", 15);
    DONE = 1'b1;
    REQ  = '0;
    tick();
    DONE = 1'b0;
    tick();

    // Hold-limit timeout on requester 4
    REQ = 16'h0010;
    tick();
    expect_grant("t4_grant", 4);
    for (int c = 2; c <= 15; c++) begin
      tick();
      check("t4_hold_valid", 32'(GNT_VALID), 32'd1);
      check("t4_hold_to",    32'(TIMEOUT),   32'd0);
    end
    tick();
    expect_idle("t4_timeout", 1'b1);
    tick();
    expect_grant("t4_regrant", 4);
    check("t4_to_clear", 32'(TIMEOUT), 32'd0);
    REQ = '0;
    tick();
    expect_idle("t4_drop", 1'b0);
    tick();

    // Dropped request on owner 3, then 0x28 grants 5
    REQ = 16'h0008;
    tick();
    expect_grant("t5_g3", 3);
    REQ = '0;
    tick();
    expect_idle("t5_drop", 1'b0);
    REQ = 16'h0028;
    tick();
    expect_grant("t5_g5", 5);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    REQ  = '0;
    tick();

    // Asynchronous reset mid-grant
    REQ = 16'h0200;
    tick();
    expect_grant("t6_g9", 9);
    #2;
    RST = 1'b1;
    #1;
    check("t6_async_gnt",   32'(GNT),       32'd0);
    check("t6_async_valid", 32'(GNT_VALID), 32'd0);
    check("t6_async_idx",   32'(GNT_IDX),   32'd0);
    tick();
    RST = 1'b0;
    REQ = 16'h0201;
    tick();
    expect_grant("t6_g0", 0);
    DONE = 1'b1;
    tick();
    expect_idle("t6_rel0", 1'b0);
    DONE = 1'b0;
    tick();
    expect_grant("t6_g9b", 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
